// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-addressed memory; sub-word stores are read-modify-write.
// Latency: loads respond 1 cycle after acceptance (2 if split); busy stalls the core while a split
// access runs. MISALIGN_SPLIT_EN selects splitting (defined) or rejecting (undefined) spanning accesses.
module load_store_unit #(
   parameter int ADDRSIZE = 32,
   parameter int WORDSIZE = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDRSIZE-1:0] req_addr,
   input  logic [WORDSIZE-1:0] req_wdata,
   output logic                busy,
   output logic                resp_valid,
   output logic [WORDSIZE-1:0] resp_rdata,
   output logic                misalign_err,
   output logic                mem_wren,
   output logic                mem_rden,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic [WORDSIZE-1:0] mem_d,
   input  logic [WORDSIZE-1:0] mem_q
);
   localparam int WIDX = ADDRSIZE - 2;

   function automatic logic [WORDSIZE-1:0] merge_lanes(input logic [WORDSIZE-1:0] old_word,
                                                       input logic [WORDSIZE-1:0] new_word,
                                                       input logic [3:0]          lanes);
      logic [WORDSIZE-1:0] res;
      res = old_word;
      for (int k = 0; k < 4; k++) begin
         if (lanes[k]) res[8*k +: 8] = new_word[8*k +: 8];
      end
      return res;
   endfunction

   function automatic logic [WORDSIZE-1:0] extend(input logic [WORDSIZE-1:0] raw,
                                                  input logic [1:0]          size,
                                                  input logic                uns);
      case (size)
         2'b00:   return {{(WORDSIZE-8){~uns & raw[7]}}, raw[7:0]};
         2'b01:   return {{(WORDSIZE-16){~uns & raw[15]}}, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   logic [1:0]          req_off;
   logic [3:0]          size_mask;
   logic                req_span;
   logic [3:0]          lo_mask;
   logic [WORDSIZE-1:0] lo_wdata;
   logic [WORDSIZE-1:0] idle_raw;
   logic [ADDRSIZE-1:0] word_a;
   logic                load_done;
   logic [WORDSIZE-1:0] load_data;

   assign req_off = req_addr[1:0];

   always_comb begin
      case (req_size)
         2'b00: begin
            size_mask = 4'b0001;
            req_span  = 1'b0;
         end
         2'b01: begin
            size_mask = 4'b0011;
            req_span  = (req_off == 2'd3);
         end
         default: begin
            size_mask = 4'b1111;
            req_span  = (req_off != 2'd0);
         end
      endcase
   end

   // Low-word lanes: truncation drops whatever overflows into the next word.
   assign lo_mask  = size_mask << req_off;
   assign lo_wdata = req_wdata << {req_off, 3'b000};
   assign idle_raw = mem_q >> {req_off, 3'b000};
   assign word_a   = {2'b00, req_addr[ADDRSIZE-1:2]};

`ifdef MISALIGN_SPLIT_EN
   typedef enum logic {IDLE, SPLIT} state_t;

   typedef struct packed {
      logic                we;
      logic [1:0]          size;
      logic                uns;
      logic [1:0]          off;
      logic [3:0]          hi_mask;
      logic [WORDSIZE-1:0] hi_wdata;
      logic [ADDRSIZE-1:0] addr;
      logic [WORDSIZE-1:0] lo_word;
   } split_t;

   state_t                state, state_nxt;
   split_t                lat;
   logic [WIDX-1:0]       word_next;
   logic [3:0]            hi_mask;
   logic [WORDSIZE-1:0]   hi_wdata;
   logic [2*WORDSIZE-1:0] split_cat;
   logic [WORDSIZE-1:0]   split_raw;

   assign word_next = req_addr[ADDRSIZE-1:2] + WIDX'(1);
   // Shift by 4 lanes (off=0) empties the high part, so non-spanning requests latch nothing.
   assign hi_mask   = size_mask >> (3'd4 - {1'b0, req_off});
   assign hi_wdata  = req_wdata >> (6'd32 - {1'b0, req_off, 3'b000});
   assign split_cat = {mem_q, lat.lo_word};
   assign split_raw = WORDSIZE'(split_cat >> {lat.off, 3'b000});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid && req_span) state_nxt = SPLIT;
         SPLIT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat <= '0;
      end else if (state == IDLE && req_valid && req_span) begin
         lat.we       <= req_we;
         lat.size     <= req_size;
         lat.uns      <= req_unsigned;
         lat.off      <= req_off;
         lat.hi_mask  <= hi_mask;
         lat.hi_wdata <= hi_wdata;
         lat.addr     <= {2'b00, word_next};
         lat.lo_word  <= mem_q;
      end
   end

   always_comb begin
      busy      = 1'b0;
      mem_rden  = 1'b0;
      mem_wren  = 1'b0;
      mem_addr  = '0;
      mem_d     = '0;
      load_done = 1'b0;
      load_data = '0;
      if (state == SPLIT) begin
         busy     = 1'b1;
         mem_rden = 1'b1;
         mem_addr = lat.addr;
         if (lat.we) begin
            mem_wren = 1'b1;
            mem_d    = merge_lanes(mem_q, lat.hi_wdata, lat.hi_mask);
         end else begin
            load_done = 1'b1;
            load_data = extend(split_raw, lat.size, lat.uns);
         end
      end else if (req_valid) begin
         busy     = req_span;
         mem_rden = 1'b1;
         mem_addr = word_a;
         if (req_we) begin
            mem_wren = 1'b1;
            mem_d    = merge_lanes(mem_q, lo_wdata, lo_mask);
         end else if (!req_span) begin
            load_done = 1'b1;
            load_data = extend(idle_raw, req_size, req_unsigned);
         end
      end
   end

   assign misalign_err = 1'b0;
`else
   logic err_set;

   // Rejected loads still respond, with zero data.
   always_comb begin
      mem_rden  = 1'b0;
      mem_wren  = 1'b0;
      mem_addr  = '0;
      mem_d     = '0;
      load_done = 1'b0;
      load_data = '0;
      err_set   = 1'b0;
      if (req_valid) begin
         if (req_span) begin
            err_set   = 1'b1;
            load_done = ~req_we;
         end else begin
            mem_rden = 1'b1;
            mem_addr = word_a;
            if (req_we) begin
               mem_wren = 1'b1;
               mem_d    = merge_lanes(mem_q, lo_wdata, lo_mask);
            end else begin
               load_done = 1'b1;
               load_data = extend(idle_raw, req_size, req_unsigned);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_err <= 1'b0;
      else     misalign_err <= err_set;
   end

   assign busy = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= load_done;
         if (load_done) resp_rdata <= load_data;
      end
   end
endmodule
